// File: rtl/loacla_arb_pkg.sv
// Shared constants, payload types and the round-robin pointer helper for the
// loacla16 adder arbiter.
package loacla_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned ID_W_DEF    = 2;
    localparam int unsigned WIDTH       = 16;
    localparam int unsigned RES_W       = 17;

    typedef logic [WIDTH-1:0] operand_t;
    typedef logic [RES_W-1:0] result_t;

    // Pointer value after requester k wins: the one just above it, wrapping.
    function automatic int unsigned rr_next(input int unsigned k, input int unsigned num_req);
        return (k + 1) % num_req;
    endfunction

endpackage

// File: rtl/loacla16_rr_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or above ptr,
// wrapping modulo NUM_REQ.
//   req   : request vector
//   ptr   : highest-priority index
//   en    : grant allowed this cycle
//   grant : one-hot grant, zero when nothing granted
//   idx   : encoded grant index (0 when nothing granted)
//   found : a grant was issued
module rr_arbiter
    import loacla_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ID_W    = ID_W_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    int unsigned j;

    // Walk from ptr upward; the first hit wins and blocks later hits.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = (32'(ptr) + i) % NUM_REQ;
            if (en && !found && req[j]) begin
                found    = 1'b1;
                idx      = ID_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lower_part_or_carry_lookahead_adder16.sv
// Lower-part-OR approximate adder, 16-bit operands, 17-bit result.
//   a, b : operands
//   sum  : result, carry-out in bit 16
// The low byte is the bitwise OR of the operands; the high byte is an exact
// generate/propagate carry-lookahead sum whose carry-in is the AND of the
// low-part MSBs.
module lower_part_or_carry_lookahead_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [16:0] sum
);

    localparam int unsigned LOW_W  = 8;
    localparam int unsigned HIGH_W = 8;

    logic [HIGH_W-1:0] g;
    logic [HIGH_W-1:0] p;
    logic [HIGH_W:0]   c;

    assign g = a[15:LOW_W] & b[15:LOW_W];
    assign p = a[15:LOW_W] ^ b[15:LOW_W];

    // Carry chain for the exact upper part.
    always_comb begin
        c    = '0;
        c[0] = a[LOW_W-1] & b[LOW_W-1];
        for (int unsigned i = 0; i < HIGH_W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum[LOW_W-1:0]  = a[LOW_W-1:0] | b[LOW_W-1:0];
    assign sum[15:LOW_W]   = p ^ c[HIGH_W-1:0];
    assign sum[16]         = c[HIGH_W];

endmodule

// File: rtl/loacla16_rr_arbiter.sv
// Shares one approximate 16-bit adder between NUM_REQ requesters with a
// round-robin valid/ready front end and a single registered, ID-tagged result.
//   clk_i, rst_i  : clock, async active-high reset
//   req_valid_i   : per-requester operation valid
//   req_ready_o   : per-requester accept (one-hot or zero)
//   req_add1_i    : packed operand 1, requester k at [16k+15:16k]
//   req_add2_i    : packed operand 2, same packing
//   res_valid_o   : result valid
//   res_ready_i   : consumer accepts result
//   res_id_o      : owner of the current result
//   result_o      : adder result, carry-out in bit 16
//   ops_count_o   : accepted-operation counter, wraps silently
module loacla16_rr_arbiter
    import loacla_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ID_W    = ID_W_DEF,
    parameter int unsigned WIDTH   = loacla_arb_pkg::WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_add1_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_add2_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [ID_W-1:0]          res_id_o,
    output result_t                  result_o,
    output logic [15:0]              ops_count_o
);

    logic               accept_en;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    grant_idx;
    logic               xfer;
    operand_t           op_a;
    operand_t           op_b;
    result_t            sum;

    // Output register can take a new result when empty or draining now.
    assign accept_en = !res_valid_o || res_ready_i;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid_i),
        .ptr   (ptr_q),
        .en    (accept_en && !rst_i),
        .grant (req_ready_o),
        .idx   (grant_idx),
        .found (xfer)
    );

    // Operand mux driven by the winning index.
    always_comb begin
        op_a = req_add1_i[32'(grant_idx)*WIDTH +: WIDTH];
        op_b = req_add2_i[32'(grant_idx)*WIDTH +: WIDTH];
    end

    lower_part_or_carry_lookahead_adder16 u_add (
        .a   (op_a),
        .b   (op_b),
        .sum (sum)
    );

    // Result register, RR pointer and operation counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_valid_o <= 1'b0;
            res_id_o    <= '0;
            result_o    <= '0;
            ptr_q       <= '0;
            ops_count_o <= '0;
        end else if (xfer) begin
            res_valid_o <= 1'b1;
            res_id_o    <= grant_idx;
            result_o    <= sum;
            ptr_q       <= ID_W'(rr_next(32'(grant_idx), NUM_REQ));
            ops_count_o <= ops_count_o + 16'd1;
        end else if (res_ready_i) begin
            res_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_loacla16_rr_arbiter.sv
// Directed bench for loacla16_rr_arbiter with hand-computed expectations.
module tb_loacla16_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [63:0] a1;
    logic [63:0] a2;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [16:0] result;
    logic [15:0] ops;

    int total = 0;
    int bad   = 0;

    logic [3:0]  pend;
    logic [63:0] pa1;
    logic [63:0] pa2;

    logic [1:0]  rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [16:0] rr_res [5] = '{17'h01111, 17'h10000, 17'h00001, 17'h0FFFF, 17'h01111};

    loacla16_rr_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (valid),
        .req_ready_o (ready),
        .req_add1_i  (a1),
        .req_add2_i  (a2),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_id_o    (res_id),
        .result_o    (result),
        .ops_count_o (ops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requester rule: a pending request keeps valid and operands until taken.
    always @(negedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (pend[k]) begin
                    total++;
                    assert (valid[k] && a1[16*k +: 16] == pa1[16*k +: 16]
                            && a2[16*k +: 16] == pa2[16*k +: 16]) else begin
                        bad++;
                        $error("FAIL hold_req%0d: observed valid=%0b expected valid=1 with stable operands", k, valid[k]);
                    end
                end
            end
            pend <= valid & ~ready;
            pa1  <= a1;
            pa2  <= a2;
        end
    end

    initial begin
        rst = 1'b1; valid = '0; a1 = '0; a2 = '0; res_ready = 1'b0;

        // Reset, then idle
        step(); step();
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_ops",   32'(ops), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_id",    32'(res_id), 0);
        rst = 1'b0;
        step();
        chk("idle_valid", 32'(res_valid), 0);
        chk("idle_ready", 32'(ready), 0);
        chk("idle_ops",   32'(ops), 0);

        // Single request from req0
        a1[15:0] = 16'h5555; a2[15:0] = 16'hAAAA; valid = 4'b0001; res_ready = 1'b1;
        #1 chk("single_ready", 32'(ready), 32'h1);
        step(); valid = '0;
        chk("single_valid",  32'(res_valid), 1);
        chk("single_id",     32'(res_id), 0);
        chk("single_result", 32'(result), 32'h0FFFF);
        chk("single_ops",    32'(ops), 1);
        step();
        chk("drain_valid", 32'(res_valid), 0);
        chk("drain_ops",   32'(ops), 1);

        // Approximate low part via req3 (ptr is 1 here)
        a1[63:48] = 16'h00FF; a2[63:48] = 16'h0001; valid = 4'b1000;
        #1 chk("apx1_ready", 32'(ready), 32'h8);
        step();
        chk("apx1_result", 32'(result), 32'h000FF);
        chk("apx1_id",     32'(res_id), 3);
        a1[63:48] = 16'h0080; a2[63:48] = 16'h0080;
        #1 chk("apx2_ready", 32'(ready), 32'h8);
        step(); valid = '0;
        chk("apx2_result", 32'(result), 32'h00180);
        chk("apx2_ops",    32'(ops), 3);
        step();
        chk("apx_drain", 32'(res_valid), 0);

        // Round-robin, all four valid, ptr back at 0
        a1 = {16'hF0F0, 16'h0000, 16'h8000, 16'h1100};
        a2 = {16'h0F0F, 16'h0001, 16'h8000, 16'h0011};
        valid = 4'b1111;
        #1 chk("rr_ready0", 32'(ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rr_id%0d", i),  32'(res_id), 32'(rr_id[i]));
            chk($sformatf("rr_res%0d", i), 32'(result), 32'(rr_res[i]));
        end
        chk("rr_ops", 32'(ops), 8);

        // Async reset between edges
        #2 rst = 1'b1;
        #1;
        chk("arst_valid",  32'(res_valid), 0);
        chk("arst_ready",  32'(ready), 0);
        chk("arst_ops",    32'(ops), 0);
        chk("arst_result", 32'(result), 0);
        step(); rst = 1'b0;
        #1 chk("arst_grant0", 32'(ready), 32'h1);
        step(); valid = 4'b1110;
        chk("post_id0",  32'(res_id), 0);
        chk("post_res0", 32'(result), 32'h01111);
        chk("post_ops",  32'(ops), 1);
        step(); valid = 4'b1100;
        chk("post_id1", 32'(res_id), 1);
        step(); valid = 4'b1000;
        chk("post_id2", 32'(res_id), 2);
        step(); valid = 4'b0000;
        chk("post_id3",  32'(res_id), 3);
        chk("post_res3", 32'(result), 32'h0FFFF);
        chk("post_ops4", 32'(ops), 4);
        step();
        chk("post_drain", 32'(res_valid), 0);

        // Backpressure with req1 and req2 pending
        res_ready = 1'b0; valid = 4'b0110;
        #1 chk("bp_first_ready", 32'(ready), 32'h2);
        step(); valid = 4'b0100;
        chk("bp_valid",  32'(res_valid), 1);
        chk("bp_result", 32'(result), 32'h10000);
        chk("bp_ops",    32'(ops), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_ready%0d", i),  32'(ready), 0);
            chk($sformatf("bp_result%0d", i), 32'(result), 32'h10000);
            chk($sformatf("bp_id%0d", i),     32'(res_id), 1);
            step();
        end
        chk("bp_hold_valid", 32'(res_valid), 1);
        res_ready = 1'b1;
        #1 chk("bp_refill_ready", 32'(ready), 32'h4);
        step(); valid = '0;
        chk("bp_refill_id",     32'(res_id), 2);
        chk("bp_refill_result", 32'(result), 32'h00001);
        chk("bp_refill_valid",  32'(res_valid), 1);
        chk("bp_refill_ops",    32'(ops), 6);
        step();
        chk("bp_drain", 32'(res_valid), 0);

        // Counter wrap: 65536 ops of 0+0 from req0
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 chk("wrap_start", 32'(ops), 0);
        a1[15:0] = 16'h0000; a2[15:0] = 16'h0000; valid = 4'b0001;
        repeat (65535) step();
        chk("wrap_ffff", 32'(ops), 32'hFFFF);
        step();
        chk("wrap_zero",   32'(ops), 0);
        chk("wrap_result", 32'(result), 0);
        chk("wrap_id",     32'(res_id), 0);
        step();
        chk("wrap_one", 32'(ops), 1);
        valid = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
